// File: rtl/store_buffer.sv
// store_buffer -- MEM-stage store path of the RV32I pipeline.
//
// SB/SH/SW requests are lane-aligned and given byte enables as they arrive.
// Legal stores go into a DEPTH-entry FIFO that drains to data memory over a
// req/ack handshake. Stores that are misaligned or have an illegal funct3 are
// dropped, and misalign_err pulses high for one cycle on the cycle after.
//
// Optional feature macro: STORE_FWD_EN
//   defined   : load_hazard flags a load whose word address matches any
//               pending entry
//   undefined : load_addr is ignored and load_hazard is tied to 0
//
// Ports:
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   store_valid    MEM stage presents a store this cycle
//   funct3M        store type: 000 SB, 001 SH, 010 SW
//   addr, wdata    byte address and unaligned rs2 data of the store
//   store_ready    buffer not full
//   stall          a legal store is presented while the buffer is full
//   misalign_err   previous cycle's store was rejected
//   buf_empty      no pending stores (FENCE drain)
//   mem_req        head entry valid toward memory
//   mem_addr       word address of the head entry
//   mem_wdata      lane-aligned data of the head entry
//   mem_be         byte enables of the head entry
//   mem_ack        memory accepted the head entry this cycle
//   load_addr      MEM-stage load address
//   load_hazard    load word matches a pending store

// One byte lane of the aligner. Each lane picks its source byte, then sets its
// enable from the low address bits.
module store_buffer_lane #(
    parameter int LANE = 0
) (
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_off,
    input  logic [7:0] i_sb_byte,   // wdata[7:0]
    input  logic [7:0] i_sh_byte,   // low or high byte of wdata[15:0] for this lane
    input  logic [7:0] i_sw_byte,   // wdata byte for this lane
    output logic [7:0] o_data,
    output logic       o_be
);
    localparam logic [1:0] LI = 2'(LANE);

    always_comb begin
        o_data = '0;
        o_be   = 1'b0;
        case (i_funct3)
            3'b000: begin o_data = i_sb_byte; o_be = (i_off == LI);       end
            3'b001: begin o_data = i_sh_byte; o_be = (i_off[1] == LI[1]); end
            3'b010: begin o_data = i_sw_byte; o_be = 1'b1;                end
            default: ;
        endcase
    end
endmodule

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          store_valid,
    input  logic [2:0]    funct3M,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          store_ready,
    output logic          stall,
    output logic          misalign_err,
    output logic          buf_empty,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [AW-1:0] load_addr,
    output logic          load_hazard
);
    localparam int PW        = $clog2(DEPTH);
    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic [AW-3:0] wa;      // word address, addr[AW-1:2]
        logic [31:0]   data;
        logic [3:0]    be;
    } sb_entry_t;

    sb_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic                  r_misalign;

    logic [NUM_LANES-1:0][7:0] w_lane_data;
    logic [NUM_LANES-1:0]      w_lane_be;
    logic                      w_legal;
    logic                      w_enq;
    logic                      w_deq;
    sb_entry_t                 w_head;

    // Alignment: one lane instance per byte
    genvar gl;
    generate
        for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
            store_buffer_lane #(.LANE(gl)) u_lane (
                .i_funct3  (funct3M),
                .i_off     (addr[1:0]),
                .i_sb_byte (wdata[7:0]),
                .i_sh_byte (wdata[8*(gl%2) +: 8]),
                .i_sw_byte (wdata[8*gl +: 8]),
                .o_data    (w_lane_data[gl]),
                .o_be      (w_lane_be[gl])
            );
        end
    endgenerate

    always_comb begin
        case (funct3M)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~addr[0];
            3'b010:  w_legal = (addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // Readiness depends only on the registered count, so an ack in the same
    // cycle cannot make room for a new store in that cycle.
    assign store_ready = (r_count != (PW+1)'(DEPTH));
    // A rejected store is dropped, so it never waits on a full buffer.
    assign stall       = store_valid & w_legal & ~store_ready;
    assign w_enq       = store_valid & w_legal & store_ready;
    assign mem_req     = (r_count != '0);
    assign w_deq       = mem_req & mem_ack;
    assign buf_empty   = (r_count == '0);
    assign misalign_err = r_misalign;

    assign w_head    = r_mem[r_rd_ptr];
    assign mem_addr  = {w_head.wa, 2'b00};
    assign mem_wdata = w_head.data;
    assign mem_be    = w_head.be;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= store_valid & ~w_legal;
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset. Liveness is tracked only by the pointers and the count.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= '{wa: addr[AW-1:2], data: w_lane_data, be: w_lane_be};
    end

`ifdef STORE_FWD_EN
    // An entry is live when its distance from the head is below count.
    logic [DEPTH-1:0] w_hit;
    logic [1:0]       w_unused_la;
    assign w_unused_la = load_addr[1:0];

    genvar ge;
    generate
        for (ge = 0; ge < DEPTH; ge++) begin : g_fwd
            logic [PW-1:0] w_rel;
            assign w_rel     = PW'(ge) - r_rd_ptr;
            assign w_hit[ge] = ({1'b0, w_rel} < r_count) &&
                               (r_mem[ge].wa == load_addr[AW-1:2]);
        end
    endgenerate
    assign load_hazard = |w_hit;
`else
    logic w_unused_la;
    assign w_unused_la = ^load_addr;
    assign load_hazard = 1'b0;
`endif
endmodule
